// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the parametrised keypad code lock.
// Latency: none (types, constants and an elaboration-time function only).
// Backpressure: not applicable.
package code_lock_pkg;

  // Lock controller states
  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    PASS,
    FAIL,
    INVALID,
    LOCKOUT
  } state_t;

  // Result codes driven on the status port
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_INV  = 2'b11;

  // Ceiling log2, never below 1 so every derived bus keeps at least one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Loadable down-counter shared by the entry-timeout, result-hold and lockout phases.
// Latency: load takes effect on the next edge; expired is a decode of the count register.
// Backpressure: none; load always wins over the decrement, the count parks at zero.
module code_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/code_lock_param.sv
// Keypad code lock: CODE_LEN-digit compare, timed result hold, lockout after MAX_TRIES misses.
// Latency: every output is registered and updates on the edge that samples the strobe.
// Backpressure: none; strobes arriving in result or lockout states are dropped.
module code_lock_param
  import code_lock_pkg::*;
#(
  parameter int                          DIGIT_W     = 4,
  parameter int                          CODE_LEN    = 3,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE        = 12'hCCD,
  parameter int                          MAX_TRIES   = 3,
  parameter int                          TIMEOUT_CYC = 1000,
  parameter int                          HOLD_CYC    = 100,
  parameter int                          LOCKOUT_CYC = 5000,
  localparam int                         DCW         = clog2(CODE_LEN + 2),
  localparam int                         FCW         = clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               enter,
  output logic [1:0]         status,
  output logic               unlock,
  output logic               locked_out,
  output logic [DCW-1:0]     digit_cnt,
  output logic [FCW-1:0]     fail_cnt
);

  localparam int TMAX0 = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
  localparam int TMAX  = (TMAX0 > LOCKOUT_CYC) ? TMAX0 : LOCKOUT_CYC;
  localparam int TW    = clog2(TMAX + 1);

  // A phase lasting N cycles loads N-1 so the exit fires on the Nth edge
  localparam logic [TW-1:0]  T_TIMEOUT = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]  T_HOLD    = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]  T_LOCK    = TW'(LOCKOUT_CYC - 1);
  localparam logic [DCW-1:0] LEN_D     = DCW'(CODE_LEN);
  localparam logic [DCW-1:0] OVR_D     = DCW'(CODE_LEN + 1);
  localparam logic [FCW-1:0] MAX_F     = FCW'(MAX_TRIES);

  state_t         state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [FCW-1:0] fail_q, fail_d;
  logic           mism_q, mism_d;
  logic [1:0]     status_q, status_d;
  logic           unlock_q, unlock_d;
  logic           lock_q, lock_d;

  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_exp;

  logic [DCW-1:0]     dig_idx;
  logic [DIGIT_W-1:0] exp_dig;
  logic               dig_ne;
  logic [FCW-1:0]     fail_inc;

  code_lock_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  // Pick the expected code digit for the position about to be entered (first digit is the MSB)
  always_comb begin
    dig_idx = (state_q == ENTRY) ? dcnt_q : '0;
    exp_dig = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (dig_idx == DCW'(i)) exp_dig = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
    dig_ne   = (digit_in != exp_dig);
    fail_inc = (fail_q == MAX_F) ? fail_q : fail_q + 1'b1;
  end

  // Next-state, attempt bookkeeping, timer reloads and registered output decode
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    mism_d   = mism_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE: begin
        // Enter outranks a coincident digit: an empty submission
        if (enter) begin
          state_d  = INVALID;
          fail_d   = fail_inc;
          tmr_load = 1'b1;
          tmr_val  = T_HOLD;
        end else if (digit_valid) begin
          state_d  = ENTRY;
          dcnt_d   = DCW'(1);
          mism_d   = dig_ne;
          tmr_load = 1'b1;
          tmr_val  = T_TIMEOUT;
        end
      end

      ENTRY: begin
        if (enter) begin
          tmr_load = 1'b1;
          tmr_val  = T_HOLD;
          // Short and overlong attempts both miss the exact length
          if (dcnt_q != LEN_D) begin
            state_d = INVALID;
            fail_d  = fail_inc;
          end else if (!mism_q) begin
            state_d = PASS;
            fail_d  = '0;
          end else begin
            state_d = FAIL;
            fail_d  = fail_inc;
          end
        end else if (digit_valid) begin
          tmr_load = 1'b1;
          tmr_val  = T_TIMEOUT;
          // Mismatches accumulate silently so the failing position is never exposed
          if (dcnt_q < LEN_D) begin
            mism_d = mism_q | dig_ne;
            dcnt_d = dcnt_q + 1'b1;
          end else begin
            dcnt_d = OVR_D;
          end
        end else if (tmr_exp) begin
          // Abandoned attempt: discard quietly, the fail count is untouched
          state_d = IDLE;
          dcnt_d  = '0;
          mism_d  = 1'b0;
        end
      end

      PASS, FAIL, INVALID: begin
        if (tmr_exp) begin
          if (fail_q == MAX_F) begin
            state_d  = LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = T_LOCK;
          end else begin
            state_d = IDLE;
            dcnt_d  = '0;
            mism_d  = 1'b0;
          end
        end
      end

      LOCKOUT: begin
        if (tmr_exp) begin
          state_d = IDLE;
          fail_d  = '0;
          dcnt_d  = '0;
          mism_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        mism_d  = 1'b0;
      end
    endcase

    status_d = ST_NONE;
    unlock_d = 1'b0;
    lock_d   = 1'b0;
    case (state_d)
      PASS: begin
        status_d = ST_PASS;
        unlock_d = 1'b1;
      end
      FAIL:    status_d = ST_FAIL;
      INVALID: status_d = ST_INV;
      LOCKOUT: begin
        status_d = ST_FAIL;
        lock_d   = 1'b1;
      end
      default: status_d = ST_NONE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      mism_q   <= 1'b0;
      fail_q   <= '0;
      status_q <= ST_NONE;
      unlock_q <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      mism_q   <= mism_d;
      fail_q   <= fail_d;
      status_q <= status_d;
      unlock_q <= unlock_d;
      lock_q   <= lock_d;
    end
  end

  assign status     = status_q;
  assign unlock     = unlock_q;
  assign locked_out = lock_q;
  assign digit_cnt  = dcnt_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_code_lock_param.sv
// Bench for code_lock_param: default lock (directed table + corner sequences),
// six-digit single-try lock, and a short-timer two-digit lock under random attempts.
module tb_code_lock_param;

  localparam int TO_A   = 1000;
  localparam int HOLD_A = 100;
  localparam int LOCK_A = 5000;
  localparam int TO_C   = 20;
  localparam int HOLD_C = 6;
  localparam int LOCK_C = 30;
  localparam int MAX_C  = 2;

  typedef struct {
    logic [19:0] dg;   // digits left-aligned, first entered digit in [19:16]
    int          n;
    int          est;
    int          edc;
    int          efc;
  } vec_t;

  logic       clk;
  logic       clr_v [3];
  logic [3:0] din   [3];
  logic       dv    [3];
  logic       en    [3];

  logic [1:0] st_a, st_b, st_c;
  logic       unl_a, unl_b, unl_c;
  logic       lko_a, lko_b, lko_c;
  logic [2:0] dc_a, dc_b;
  logic [1:0] dc_c;
  logic [1:0] fc_a;
  logic       fc_b;
  logic [1:0] fc_c;

  logic [3:0] code_c [2];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  code_lock_param u_a (
    .clk(clk), .clr(clr_v[0]), .digit_in(din[0]), .digit_valid(dv[0]), .enter(en[0]),
    .status(st_a), .unlock(unl_a), .locked_out(lko_a), .digit_cnt(dc_a), .fail_cnt(fc_a)
  );

  code_lock_param #(
    .DIGIT_W(4), .CODE_LEN(6), .CODE(24'h123456), .MAX_TRIES(1)
  ) u_b (
    .clk(clk), .clr(clr_v[1]), .digit_in(din[1]), .digit_valid(dv[1]), .enter(en[1]),
    .status(st_b), .unlock(unl_b), .locked_out(lko_b), .digit_cnt(dc_b), .fail_cnt(fc_b)
  );

  code_lock_param #(
    .DIGIT_W(4), .CODE_LEN(2), .CODE(8'h5A), .MAX_TRIES(MAX_C),
    .TIMEOUT_CYC(TO_C), .HOLD_CYC(HOLD_C), .LOCKOUT_CYC(LOCK_C)
  ) u_c (
    .clk(clk), .clr(clr_v[2]), .digit_in(din[2]), .digit_valid(dv[2]), .enter(en[2]),
    .status(st_c), .unlock(unl_c), .locked_out(lko_c), .digit_cnt(dc_c), .fail_cnt(fc_c)
  );

  function automatic int g_st(input int k);
    if (k == 0) return int'(st_a);
    if (k == 1) return int'(st_b);
    return int'(st_c);
  endfunction

  function automatic int g_unl(input int k);
    if (k == 0) return int'(unl_a);
    if (k == 1) return int'(unl_b);
    return int'(unl_c);
  endfunction

  function automatic int g_lko(input int k);
    if (k == 0) return int'(lko_a);
    if (k == 1) return int'(lko_b);
    return int'(lko_c);
  endfunction

  function automatic int g_dc(input int k);
    if (k == 0) return int'(dc_a);
    if (k == 1) return int'(dc_b);
    return int'(dc_c);
  endfunction

  function automatic int g_fc(input int k);
    if (k == 0) return int'(fc_a);
    if (k == 1) return int'(fc_b);
    return int'(fc_c);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // edc < 0 means digit_cnt is not defined in that state and is not compared
  task automatic chk_o(input string nm, input int k, input int est, input int eunl,
                       input int elk, input int edc, input int efc);
    chk({nm, ".status"}, g_st(k), est);
    chk({nm, ".unlock"}, g_unl(k), eunl);
    chk({nm, ".locked_out"}, g_lko(k), elk);
    if (edc >= 0) chk({nm, ".digit_cnt"}, g_dc(k), edc);
    chk({nm, ".fail_cnt"}, g_fc(k), efc);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input logic [3:0] d);
    din[k] = d;
    dv[k]  = 1'b1;
    tick(1);
    dv[k]  = 1'b0;
  endtask

  task automatic press_enter(input int k);
    en[k] = 1'b1;
    tick(1);
    en[k] = 1'b0;
  endtask

  task automatic enter_code_a(input logic [11:0] c);
    press(0, c[11:8]);
    press(0, c[7:4]);
    press(0, c[3:0]);
    press_enter(0);
  endtask

  initial begin
    vec_t tbl [10];
    int   mf;

    tbl[0] = '{20'hCCD00, 3, 1, 3, 0};
    tbl[1] = '{20'hCAD00, 3, 2, 3, 1};
    tbl[2] = '{20'hCC000, 2, 3, 2, 2};
    tbl[3] = '{20'hCCD00, 3, 1, 3, 0};
    tbl[4] = '{20'hCCDD0, 4, 3, 4, 1};
    tbl[5] = '{20'h00000, 0, 3, 0, 2};
    tbl[6] = '{20'hCCD00, 3, 1, 3, 0};
    tbl[7] = '{20'hDCC00, 3, 2, 3, 1};
    tbl[8] = '{20'h12345, 5, 3, 4, 2};
    tbl[9] = '{20'hCCD00, 3, 1, 3, 0};

    code_c[0] = 4'h5;
    code_c[1] = 4'hA;

    for (int k = 0; k < 3; k++) begin
      clr_v[k] = 1'b0;
      din[k]   = 4'h0;
      dv[k]    = 1'b0;
      en[k]    = 1'b0;
    end

    // ---------------- reset ----------------
    #2;
    for (int k = 0; k < 3; k++) clr_v[k] = 1'b1;
    #10;
    chk_o("reset_a", 0, 0, 0, 0, 0, 0);
    chk_o("reset_b", 1, 0, 0, 0, 0, 0);
    chk_o("reset_c", 2, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) clr_v[k] = 1'b0;
    tick(2);

    // ---------------- table of attempts on the default lock ----------------
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < tbl[i].n; j++) press(0, tbl[i].dg[19-4*j -: 4]);
      if (tbl[i].n > 0) chk($sformatf("tbl%0d.pre_enter_status", i), g_st(0), 0);
      press_enter(0);
      chk_o($sformatf("tbl%0d", i), 0, tbl[i].est, int'(tbl[i].est == 1), 0,
            tbl[i].edc, tbl[i].efc);
      tick(HOLD_A - 1);
      chk($sformatf("tbl%0d.hold_last", i), g_st(0), tbl[i].est);
      tick(1);
      chk_o($sformatf("tbl%0d.idle", i), 0, 0, 0, 0, 0, tbl[i].efc);
    end

    // ---------------- entry timeout leaves fail count alone ----------------
    enter_code_a(12'hCAD);
    chk("to_setup.fail_cnt", g_fc(0), 1);
    tick(HOLD_A);
    press(0, 4'hC);
    tick(TO_A - 1);
    chk("to_before.digit_cnt", g_dc(0), 1);
    tick(1);
    chk_o("to_after", 0, 0, 0, 0, 0, 1);

    // ---------------- digit coinciding with enter is dropped ----------------
    press(0, 4'hC);
    press(0, 4'hC);
    press(0, 4'hD);
    din[0] = 4'h5;
    dv[0]  = 1'b1;
    en[0]  = 1'b1;
    tick(1);
    dv[0]  = 1'b0;
    en[0]  = 1'b0;
    chk_o("simul", 0, 1, 1, 0, 3, 0);
    tick(HOLD_A);

    // ---------------- three misses -> lockout ----------------
    for (int r = 0; r < 3; r++) begin
      enter_code_a(12'hCAD);
      chk($sformatf("lock_try%0d.status", r), g_st(0), 2);
      chk($sformatf("lock_try%0d.fail_cnt", r), g_fc(0), r + 1);
      tick(HOLD_A);
    end
    chk_o("lock_entry", 0, 2, 0, 1, -1, 3);
    enter_code_a(12'hCCD);
    chk_o("lock_ignore", 0, 2, 0, 1, -1, 3);
    tick(LOCK_A - 5);
    chk("lock_last.locked_out", g_lko(0), 1);
    tick(1);
    chk_o("lock_exit", 0, 0, 0, 0, 0, 0);
    enter_code_a(12'hCCD);
    chk_o("after_lock", 0, 1, 1, 0, 3, 0);
    tick(HOLD_A);

    // ---------------- six-digit, single-try lock ----------------
    for (int j = 0; j < 6; j++) press(1, 4'(j + 1));
    press_enter(1);
    chk_o("b_pass", 1, 1, 1, 0, 6, 0);
    tick(HOLD_A);
    chk_o("b_idle", 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) press(1, 4'(j + 1));
    press(1, 4'h7);
    press_enter(1);
    chk_o("b_fail", 1, 2, 0, 0, 6, 1);
    tick(HOLD_A);
    chk_o("b_lock", 1, 2, 0, 1, -1, 1);
    tick(50);
    clr_v[1] = 1'b1;
    #1;
    chk_o("b_clr", 1, 0, 0, 0, 0, 0);
    tick(1);
    clr_v[1] = 1'b0;
    tick(1);
    chk_o("b_clr_idle", 1, 0, 0, 0, 0, 0);

    // ---------------- random attempts against an attempt-level model ----------------
    mf = 0;
    for (int it = 0; it < 60; it++) begin
      int         n, kind, g, est, edc;
      bit         ok;
      logic [3:0] d [4];

      n    = $urandom_range(0, 4);
      kind = $urandom_range(0, 9);
      ok   = (n == 2);
      for (int j = 0; j < n; j++) begin
        d[j] = 4'($urandom_range(0, 15));
        if (j < 2) begin
          if ($urandom_range(0, 3) != 0) d[j] = code_c[j];
          if (d[j] != code_c[j]) ok = 1'b0;
        end
        press(2, d[j]);
        if (j < n - 1) begin
          g = $urandom_range(0, TO_C - 2);
          if (g > 0) tick(g);
        end
      end
      edc = (n < 3) ? n : 3;
      if (n > 0) begin
        chk("rnd_entry.status", g_st(2), 0);
        chk("rnd_entry.digit_cnt", g_dc(2), edc);
      end

      if (kind == 0 && n > 0) begin
        tick(TO_C);
        chk_o("rnd_timeout", 2, 0, 0, 0, 0, mf);
      end else begin
        g = $urandom_range(0, TO_C - 2);
        if (g > 0) tick(g);
        if (kind == 1) begin
          din[2] = 4'($urandom_range(0, 15));
          dv[2]  = 1'b1;
        end
        en[2] = 1'b1;
        tick(1);
        dv[2] = 1'b0;
        en[2] = 1'b0;

        if (n != 2)  est = 3;
        else if (ok) est = 1;
        else         est = 2;
        if (est == 1)        mf = 0;
        else if (mf < MAX_C) mf++;
        chk_o("rnd_result", 2, est, int'(est == 1), 0, edc, mf);

        for (int h = 0; h < HOLD_C; h++) begin
          din[2] = 4'($urandom_range(0, 15));
          dv[2]  = 1'($urandom_range(0, 1));
          en[2]  = 1'($urandom_range(0, 1));
          tick(1);
        end
        dv[2] = 1'b0;
        en[2] = 1'b0;

        if (mf == MAX_C) begin
          chk_o("rnd_lock", 2, 2, 0, 1, -1, mf);
          for (int h = 0; h < LOCK_C; h++) begin
            din[2] = 4'($urandom_range(0, 15));
            dv[2]  = 1'($urandom_range(0, 1));
            en[2]  = 1'($urandom_range(0, 1));
            tick(1);
          end
          dv[2] = 1'b0;
          en[2] = 1'b0;
          mf = 0;
          chk_o("rnd_unlock", 2, 0, 0, 0, 0, 0);
        end else begin
          chk_o("rnd_idle", 2, 0, 0, 0, 0, mf);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
